// File: rtl/divisor_secuencial.sv
// Sequential signed restoring divider, one quotient bit per clock.
// C semantics: quotient truncates toward zero, remainder takes dividend sign.
module divisor_secuencial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sq_q, sq_d;
  logic             sr_q, sr_d;
  logic             zp_q, zp_d;
  logic             ovp_q, ovp_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             is_ovf;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  assign abs_a = dividend[WIDTH-1] ? -dividend : dividend;
  assign abs_b = divisor[WIDTH-1] ? -divisor : divisor;
  assign is_ovf = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                  (divisor == '1);

  // Trial subtraction on a widened copy; the top bit is the borrow.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {2'b00, dvs_q};

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    sq_d        = sq_q;
    sr_d        = sr_q;
    zp_d        = zp_q;
    ovp_d       = ovp_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    dz_d        = dz_q;
    ov_d        = ov_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            zp_d    = 1'b1;
            ovp_d   = 1'b0;
            quo_d   = dividend;
            state_d = FIX;
          end else begin
            quo_d   = abs_a;
            dvs_d   = abs_b;
            sq_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sr_d    = dividend[WIDTH-1];
            rem_d   = '0;
            cnt_d   = '0;
            zp_d    = 1'b0;
            ovp_d   = is_ovf;
            state_d = ITER;
          end
        end
      end
      ITER: begin
        if (!trial[WIDTH+1]) begin
          rem_d = trial[WIDTH:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        dz_d    = zp_q;
        ov_d    = ovp_q;
        state_d = IDLE;
        // On divide-by-zero the raw dividend sits in quo_q.
        if (zp_q) begin
          quotient_d  = '0;
          remainder_d = quo_q;
        end else begin
          quotient_d  = sq_q ? -quo_q : quo_q;
          remainder_d = sr_q ? -rem_q[WIDTH-1:0]
                             : rem_q[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      sq_q        <= 1'b0;
      sr_q        <= 1'b0;
      zp_q        <= 1'b0;
      ovp_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      sq_q        <= sq_d;
      sr_q        <= sr_d;
      zp_q        <= zp_d;
      ovp_q       <= ovp_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      dz_q        <= dz_d;
      ov_q        <= ov_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign div_zero  = dz_q;
  assign overflow  = ov_q;

endmodule
